// File: rtl/decoding_stage_controller_pkg.sv
// Shared stage codes and controller state encoding for the decoding sequencer.
package decoding_stage_controller_pkg;

  localparam int STAGE_WIDTH = 3;

  localparam logic [STAGE_WIDTH-1:0] STAGE_IDLE                = 3'd0;
  localparam logic [STAGE_WIDTH-1:0] STAGE_MEASUREMENT_LOADING = 3'd1;
  localparam logic [STAGE_WIDTH-1:0] STAGE_GROW                = 3'd2;
  localparam logic [STAGE_WIDTH-1:0] STAGE_MERGE               = 3'd3;
  localparam logic [STAGE_WIDTH-1:0] STAGE_PEELING             = 3'd4;
  localparam logic [STAGE_WIDTH-1:0] STAGE_RESULT_VALID        = 3'd5;
  localparam logic [STAGE_WIDTH-1:0] STAGE_WRITE_TO_MEM        = 3'd6;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_GROW,
    ST_MERGE,
    ST_PEEL,
    ST_RESULT,
    ST_CTX_SWITCH
  } ctrl_state_e;

  // Stage code broadcast to the PE array while the controller sits in a state.
  function automatic logic [STAGE_WIDTH-1:0] stage_of(input ctrl_state_e s);
    case (s)
      ST_LOAD:       return STAGE_MEASUREMENT_LOADING;
      ST_GROW:       return STAGE_GROW;
      ST_MERGE:      return STAGE_MERGE;
      ST_PEEL:       return STAGE_PEELING;
      ST_RESULT:     return STAGE_RESULT_VALID;
      ST_CTX_SWITCH: return STAGE_WRITE_TO_MEM;
      default:       return STAGE_IDLE;
    endcase
  endfunction

endpackage

// File: rtl/decoding_stage_controller_flag_reduce_tree.sv
// OR reduction of per-PE status flags; purely combinational so the
// controller sees the aggregate in the same cycle the PEs present it.
module decoding_stage_controller_flag_reduce_tree
  import decoding_stage_controller_pkg::*;
#(
  parameter int WIDTH = 64
) (
  input  logic [WIDTH-1:0] flags,
  output logic             any_set
);

  assign any_set = |flags;

endmodule

// File: rtl/decoding_stage_controller.sv
// Global sequencer for the PE array: load, grow/merge until no odd cluster
// remains (or the iteration limit hits), peel, hand off the result, then
// rotate to the next stored context.
module decoding_stage_controller
  import decoding_stage_controller_pkg::*;
#(
  parameter int PE_COUNT     = 64,
  parameter int NUM_CONTEXTS = 2,
  parameter int MERGE_SETTLE = 3,
  parameter int PEEL_CYCLES  = 2,
  parameter int MAX_ITER     = 31,
  parameter int ITER_WIDTH   = 5,
  localparam int CTX_W = (NUM_CONTEXTS > 1) ? $clog2(NUM_CONTEXTS) : 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start_valid,
  output logic                   start_ready,
  input  logic [PE_COUNT-1:0]    pe_busy,
  input  logic [PE_COUNT-1:0]    pe_odd,
  output logic [STAGE_WIDTH-1:0] global_stage,
  output logic [CTX_W-1:0]       context_id,
  output logic [ITER_WIDTH-1:0]  iteration_count,
  output logic                   result_valid,
  input  logic                   result_ready,
  output logic                   timeout_error
);

  localparam int MCW = $clog2(MERGE_SETTLE + 1);
  localparam int PCW = (PEEL_CYCLES > 1) ? $clog2(PEEL_CYCLES) : 1;
  localparam logic [MCW-1:0]        MERGE_DONE = MCW'(MERGE_SETTLE);
  localparam logic [PCW-1:0]        PEEL_LOAD  = PCW'(PEEL_CYCLES - 1);
  localparam logic [ITER_WIDTH-1:0] ITER_LIMIT = ITER_WIDTH'(MAX_ITER);
  localparam logic [CTX_W-1:0]      CTX_LAST   = CTX_W'(NUM_CONTEXTS - 1);

  ctrl_state_e            state_q, state_d;
  logic [STAGE_WIDTH-1:0] stage_q;
  logic [MCW-1:0]         merge_cnt_q;
  logic [PCW-1:0]         peel_cnt_q;
  logic [ITER_WIDTH-1:0]  iter_q;
  logic                   timeout_q;
  logic [CTX_W-1:0]       ctx_q;
  logic                   busy_any, odd_any;
  logic                   set_timeout;

  function automatic logic [ITER_WIDTH-1:0] iter_sat_inc(input logic [ITER_WIDTH-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

  decoding_stage_controller_flag_reduce_tree #(.WIDTH(PE_COUNT)) u_busy_or (
    .flags   (pe_busy),
    .any_set (busy_any)
  );

  decoding_stage_controller_flag_reduce_tree #(.WIDTH(PE_COUNT)) u_odd_or (
    .flags   (pe_odd),
    .any_set (odd_any)
  );

  // Next-state selection; merge exit waits out the settle window because
  // busy still reflects the previous merge until the PEs re-register stage.
  always_comb begin
    state_d     = state_q;
    set_timeout = 1'b0;
    case (state_q)
      ST_IDLE:  if (start_valid) state_d = ST_LOAD;
      ST_LOAD:  state_d = ST_GROW;
      ST_GROW:  state_d = ST_MERGE;
      ST_MERGE: begin
        if (merge_cnt_q == MERGE_DONE && !busy_any) begin
          if (!odd_any) begin
            state_d = ST_PEEL;
          end else if (iter_q < ITER_LIMIT) begin
            state_d = ST_GROW;
          end else begin
            state_d     = ST_PEEL;
            set_timeout = 1'b1;
          end
        end
      end
      ST_PEEL:  if (peel_cnt_q == '0) state_d = ST_RESULT;
      ST_RESULT: begin
        if (result_ready) state_d = (NUM_CONTEXTS > 1) ? ST_CTX_SWITCH : ST_IDLE;
      end
      ST_CTX_SWITCH: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // State register with the broadcast stage code registered alongside it.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      stage_q <= STAGE_IDLE;
    end else begin
      state_q <= state_d;
      stage_q <= stage_of(state_d);
    end
  end

  // Iteration, merge-settle and peel counters plus the timeout flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      merge_cnt_q <= '0;
      peel_cnt_q  <= '0;
      iter_q      <= '0;
      timeout_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start_valid) begin
            iter_q    <= '0;
            timeout_q <= 1'b0;
          end
        end
        ST_GROW: begin
          iter_q      <= iter_sat_inc(iter_q);
          merge_cnt_q <= MCW'(1);
        end
        ST_MERGE: begin
          if (merge_cnt_q != MERGE_DONE) merge_cnt_q <= merge_cnt_q + 1'b1;
        end
        default: ;
      endcase
      if (set_timeout) timeout_q <= 1'b1;
      if (state_d == ST_PEEL && state_q != ST_PEEL) begin
        peel_cnt_q <= PEEL_LOAD;
      end else if (state_q == ST_PEEL && peel_cnt_q != '0) begin
        peel_cnt_q <= peel_cnt_q - 1'b1;
      end
    end
  end

  // Context index advances once per completed decode, wrapping at the last slot.
  always_ff @(posedge clk) begin
    if (reset) begin
      ctx_q <= '0;
    end else if (state_q == ST_CTX_SWITCH) begin
      ctx_q <= (ctx_q == CTX_LAST) ? '0 : ctx_q + 1'b1;
    end
  end

  assign start_ready     = (state_q == ST_IDLE) && !reset;
  assign result_valid    = (state_q == ST_RESULT);
  assign global_stage    = stage_q;
  assign context_id      = ctx_q;
  assign iteration_count = iter_q;
  assign timeout_error   = timeout_q;

endmodule

// File: tb/tb_decoding_stage_controller.sv
// Bench for decoding_stage_controller: a reactive PE-array driver issues
// decode rounds and queues the expected outcome; a monitor compares on
// every result cycle and on the context switch that follows.
module tb_decoding_stage_controller;
  import decoding_stage_controller_pkg::*;

  localparam int PE = 64;

  logic                   clk = 1'b0;
  logic                   reset;
  logic                   start_valid;
  logic                   start_ready;
  logic [PE-1:0]          pe_busy;
  logic [PE-1:0]          pe_odd;
  logic [STAGE_WIDTH-1:0] global_stage;
  logic [0:0]             context_id;
  logic [4:0]             iteration_count;
  logic                   result_valid;
  logic                   result_ready;
  logic                   timeout_error;

  always #5 clk = ~clk;

  decoding_stage_controller #(
    .PE_COUNT(PE), .NUM_CONTEXTS(2), .MERGE_SETTLE(3),
    .PEEL_CYCLES(2), .MAX_ITER(3), .ITER_WIDTH(5)
  ) dut (
    .clk(clk), .reset(reset),
    .start_valid(start_valid), .start_ready(start_ready),
    .pe_busy(pe_busy), .pe_odd(pe_odd),
    .global_stage(global_stage), .context_id(context_id),
    .iteration_count(iteration_count),
    .result_valid(result_valid), .result_ready(result_ready),
    .timeout_error(timeout_error)
  );

  typedef struct {
    int iter; int to; int ctx; int ctx_after;
    int grows; int merges; int peels; int results;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int fails  = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic exp_t mk(input int iter, input int to, input int ctx, input int ctx_after,
                              input int grows, input int merges, input int peels, input int results);
    exp_t e;
    e.iter = iter; e.to = to; e.ctx = ctx; e.ctx_after = ctx_after;
    e.grows = grows; e.merges = merges; e.peels = peels; e.results = results;
    return e;
  endfunction

  // Monitor: counts stage cycles per round and compares at result / context switch.
  int   n_grow, n_merge, n_peel, n_result;
  int   ctx_phase = 0;
  exp_t cur;
  always @(negedge clk) begin
    if (reset) begin
      n_grow = 0; n_merge = 0; n_peel = 0; n_result = 0; ctx_phase = 0;
    end else begin
      if (ctx_phase == 1) begin
        chk("switch_stage", int'(global_stage), int'(STAGE_WRITE_TO_MEM));
        chk("ctx_during_switch", int'(context_id), cur.ctx);
        ctx_phase = 2;
      end else if (ctx_phase == 2) begin
        chk("stage_after_switch", int'(global_stage), int'(STAGE_IDLE));
        chk("ctx_after_switch", int'(context_id), cur.ctx_after);
        ctx_phase = 0;
      end
      case (global_stage)
        STAGE_MEASUREMENT_LOADING: begin
          n_grow = 0; n_merge = 0; n_peel = 0; n_result = 0;
        end
        STAGE_GROW:         n_grow++;
        STAGE_MERGE:        n_merge++;
        STAGE_PEELING:      n_peel++;
        STAGE_RESULT_VALID: n_result++;
        default: ;
      endcase
      if (result_valid) begin
        if (sb.size() == 0) begin
          chk("unexpected_result", 1, 0);
        end else begin
          chk("iteration_count", int'(iteration_count), sb[0].iter);
          chk("timeout_error", int'(timeout_error), sb[0].to);
          chk("context_id", int'(context_id), sb[0].ctx);
          if (result_ready) begin
            cur = sb.pop_front();
            chk("grow_cycles", n_grow, cur.grows);
            chk("merge_cycles", n_merge, cur.merges);
            chk("peel_cycles", n_peel, cur.peels);
            chk("result_cycles", n_result, cur.results);
            ctx_phase = 1;
          end
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start_handshake();
    int guard;
    guard = 0;
    start_valid = 1'b1;
    while (!start_ready && guard < 50) begin
      step();
      guard++;
    end
    if (!start_ready) chk("start_ready_wait", 0, 1);
    step();
    start_valid = 1'b0;
  endtask

  // One decode: odd persists through the first odd_rounds merges, busy is
  // held for the first busy_len cycles of every merge, ready after ready_wait.
  task automatic run_round(input int odd_rounds, input int busy_len, input int ready_wait,
                           input exp_t e);
    int merge_idx, merge_no, res_cyc, guard;
    logic [STAGE_WIDTH-1:0] prev;
    logic done;
    sb.push_back(e);
    start_handshake();
    merge_idx = 0; merge_no = 0; res_cyc = 0; done = 1'b0;
    prev = STAGE_IDLE;
    for (guard = 0; guard < 500 && !done; guard++) begin
      if (global_stage == STAGE_IDLE) begin
        done = 1'b1;
        pe_busy = '0; pe_odd = '0; result_ready = 1'b0;
      end else begin
        if (global_stage == STAGE_MERGE) begin
          if (prev != STAGE_MERGE) begin
            merge_no++;
            merge_idx = 0;
          end else begin
            merge_idx++;
          end
        end
        pe_busy = (global_stage == STAGE_MERGE && merge_idx < busy_len) ? PE'(1) : '0;
        pe_odd  = (merge_no <= odd_rounds) ? (PE'(1) << 5) : '0;
        if (global_stage == STAGE_RESULT_VALID) begin
          res_cyc++;
          result_ready = (res_cyc > ready_wait);
        end else begin
          result_ready = 1'b0;
        end
        prev = global_stage;
        step();
      end
    end
    if (!done) chk("round_completion", 0, 1);
  endtask

  initial begin
    int guard;
    reset = 1'b1; start_valid = 1'b0; result_ready = 1'b0;
    pe_busy = '0; pe_odd = '0;
    step(); step();
    chk("rst_stage", int'(global_stage), int'(STAGE_IDLE));
    chk("rst_start_ready", int'(start_ready), 0);
    chk("rst_result_valid", int'(result_valid), 0);
    chk("rst_iter", int'(iteration_count), 0);
    chk("rst_timeout", int'(timeout_error), 0);
    chk("rst_ctx", int'(context_id), 0);
    reset = 1'b0;
    #1;
    chk("start_ready_after_reset", int'(start_ready), 1);

    // zero-defect round
    run_round(0, 0, 0, mk(1, 0, 0, 1, 1, 3, 2, 1));
    // two-iteration convergence
    run_round(1, 0, 0, mk(2, 0, 1, 0, 2, 6, 2, 1));
    // busy held for 7 merge cycles
    run_round(0, 7, 0, mk(1, 0, 0, 1, 1, 8, 2, 1));
    // stale busy in the settle window only
    run_round(0, 2, 0, mk(1, 0, 1, 0, 1, 3, 2, 1));
    // odd never clears: forced peel at MAX_ITER=3
    run_round(100, 0, 0, mk(3, 1, 0, 1, 3, 9, 2, 1));

    // reset pulse during MERGE
    start_handshake();
    guard = 0;
    while (global_stage != STAGE_MERGE && guard < 20) begin
      step();
      guard++;
    end
    chk("reach_merge", int'(global_stage), int'(STAGE_MERGE));
    pe_busy = '1;
    reset = 1'b1;
    step();
    pe_busy = '0;
    chk("midrst_stage", int'(global_stage), int'(STAGE_IDLE));
    chk("midrst_ctx", int'(context_id), 0);
    chk("midrst_result_valid", int'(result_valid), 0);
    chk("midrst_start_ready", int'(start_ready), 0);
    chk("midrst_iter", int'(iteration_count), 0);
    reset = 1'b0;
    #1;
    chk("midrst_start_ready_after", int'(start_ready), 1);
    step();
    chk("midrst_no_write", int'(global_stage), int'(STAGE_IDLE));

    // result backpressure for 10 cycles, then a second round to wrap context
    run_round(0, 0, 10, mk(1, 0, 0, 1, 1, 3, 2, 11));
    run_round(0, 0, 0, mk(1, 0, 1, 0, 1, 3, 2, 1));

    step(); step(); step();
    chk("scoreboard_empty", sb.size(), 0);
    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
